// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing,
// NZVC flag register, branch evaluation, memory-wait timeout and retire counter.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op,
   input  logic             is_imm,
   input  logic             is_load,
   input  logic             set_flags,
   input  logic [1:0]       cond,
   input  logic [3:0]       alu_flags,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             pc_src,
   output logic             ir_we,
   output logic             addr_src,
   output logic             mem_req,
   output logic             mem_we,
   output logic             alu_src_b,
   output logic             rf_we,
   output logic             wb_src,
   output logic [3:0]       flags_q,
   output logic             branch_taken,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC     = 4'd2,
      S_WB_ALU   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_WB_MEM   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_HALT     = 4'd9,
      S_FAULT    = 4'd10
   } state_t;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t            cur;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_hit;
   logic              take;

   function automatic logic cond_met(input logic [1:0] c, input logic n, input logic z,
                                     input logic v);
      case (c)
         2'b00:   cond_met = 1'b1;
         2'b01:   cond_met = ~z & (n == v);
         2'b10:   cond_met = 1'b0;
         default: cond_met = z;
      endcase
   endfunction

   // The limit cycle itself is the last not-ready cycle; ready on that cycle still completes.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
   assign take        = cond_met(cond, flags_q[3], flags_q[2], flags_q[1]);
   assign state       = cur;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur      <= S_FETCH;
         flags_q  <= '0;
         retired  <= '0;
         wait_cnt <= '0;
      end else begin
         wait_cnt <= '0;
         case (cur)
            S_FETCH: begin
               if (mem_ready)
                  cur <= S_DECODE;
               else if (timeout_hit)
                  cur <= S_FAULT;
               else
                  wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            S_DECODE: begin
               case (op)
                  2'b00:   cur <= S_EXEC;
                  2'b01:   cur <= S_MEM_ADDR;
                  2'b10:   cur <= S_BRANCH;
                  default: cur <= S_HALT;
               endcase
            end
            S_EXEC: begin
               if (set_flags)
                  flags_q <= alu_flags;
               cur <= S_WB_ALU;
            end
            S_WB_ALU: begin
               retired <= retired + CNT_W'(1);
               cur     <= S_FETCH;
            end
            S_MEM_ADDR: cur <= is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
               if (mem_ready)
                  cur <= S_WB_MEM;
               else if (timeout_hit)
                  cur <= S_FAULT;
               else
                  wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            S_WB_MEM: begin
               retired <= retired + CNT_W'(1);
               cur     <= S_FETCH;
            end
            S_MEM_WR: begin
               if (mem_ready) begin
                  retired <= retired + CNT_W'(1);
                  cur     <= S_FETCH;
               end else if (timeout_hit) begin
                  cur <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_BRANCH: begin
               retired <= retired + CNT_W'(1);
               cur     <= S_FETCH;
            end
            S_HALT:  cur <= S_HALT;
            S_FAULT: cur <= S_FAULT;
            default: cur <= S_FAULT;
         endcase
      end
   end

   // Outputs decode the current state plus same-cycle mem_ready; all held low during reset.
   always_comb begin
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      ir_we        = 1'b0;
      addr_src     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      alu_src_b    = 1'b0;
      rf_we        = 1'b0;
      wb_src       = 1'b0;
      branch_taken = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      if (rst) begin
         case (cur)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
               pc_we   = mem_ready;
            end
            S_EXEC:     alu_src_b = is_imm;
            S_WB_ALU:   rf_we     = 1'b1;
            S_MEM_ADDR: alu_src_b = is_imm;
            S_MEM_RD: begin
               mem_req  = 1'b1;
               addr_src = 1'b1;
            end
            S_WB_MEM: begin
               rf_we  = 1'b1;
               wb_src = 1'b1;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_src = 1'b1;
            end
            S_BRANCH: begin
               pc_we        = take;
               pc_src       = take;
               branch_taken = take;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main multi-cycle control FSM for the CPU.
- Sequences fetch, decode, execute, memory and writeback, and owns the 4-bit NZVC flag register.
- Evaluates branch conditions and drives all datapath enables: PC, IR, register file and memory.
- Includes a memory-wait timeout (fault) and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready cycles in a memory wait state before FAULT. 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- op  in  2  instruction class from IR: 00 data-proc, 01 memory, 10 branch, 11 halt
- is_imm  in  1  data-proc/memory operand B is the immediate
- is_load  in  1  memory op: 1 load, 0 store
- set_flags  in  1  data-proc op updates flags
- cond  in  2  branch condition: 00 always, 01 GT, 10 never, 11 EQ
- alu_flags  in  4  {N,Z,V,C} from ALU, current cycle
- mem_ready  in  1  memory completes the request this cycle
- pc_we  out  1  PC write enable
- pc_src  out  1  0 = PC+4, 1 = branch target
- ir_we  out  1  instruction register write enable
- addr_src  out  1  0 = PC, 1 = ALU result
- mem_req  out  1  memory request
- mem_we  out  1  memory write (valid with mem_req)
- alu_src_b  out  1  0 = register, 1 = immediate
- rf_we  out  1  register file write enable
- wb_src  out  1  0 = ALU result, 1 = memory data
- flags_q  out  4  registered {N,Z,V,C}
- branch_taken  out  1  pulse: branch taken this cycle
- halted  out  1  in HALT
- fault  out  1  in FAULT
- retired  out  CNT_W  retired-instruction count
- state  out  4  current state (debug)

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=FETCH, flags_q=0, retired=0, wait counter=0.
  - While rst=0, all outputs other than state/flags_q/retired are forced 0.
  - Reset mid-operation abandons the instruction with no pending side effects.
- States and transitions:
  - FETCH: mem_req=1, addr_src=0. When mem_ready=1 in the same cycle: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise hold.
  - DECODE: 1 cycle, no enables. Next state by op: 00→EXEC, 01→MEM_ADDR, 10→BRANCH, 11→HALT.
  - EXEC: alu_src_b=is_imm. If set_flags=1, flags_q<=alu_flags at the end of the cycle. Next: WB_ALU.
  - WB_ALU: rf_we=1, wb_src=0, retired++. Next: FETCH.
  - MEM_ADDR: alu_src_b=is_imm. Next: MEM_RD if is_load, else MEM_WR.
  - MEM_RD: mem_req=1, addr_src=1, mem_we=0. Wait for mem_ready, then go to WB_MEM.
  - WB_MEM: rf_we=1, wb_src=1, retired++. Next: FETCH.
  - MEM_WR: mem_req=1, mem_we=1, addr_src=1. On the mem_ready cycle: retired++, go to FETCH.
  - BRANCH: evaluate cond on flags_q, not alu_flags.
    - Condition terms: 00 always; 01 (GT) ~Z & (N==V); 10 never; 11 (EQ) Z.
    - If taken: pc_we=1, pc_src=1, branch_taken=1.
    - retired++ regardless of outcome. Next: FETCH.
  - HALT: halted=1, no enables. Terminal until reset.
  - FAULT: fault=1, no enables. Terminal until reset.
- Mem-ready Mealy rule: pc_we, ir_we and the MEM_WR retire depend on mem_ready in the same cycle. mem_req stays high through the ready cycle inclusive.
- Memory timeout (FETCH, MEM_RD, MEM_WR):
  - Wait counter clears on entering a wait state and increments on every mem_ready=0 cycle.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT and mem_req is 0 from then on.
  - mem_ready=1 on the same cycle the limit would be hit wins: normal completion.
- Flags: flags_q changes only in EXEC with set_flags=1. Memory, branch and halt never alter flags_q.
- Counter: retired wraps from 2^CNT_W-1 to 0. HALT, FAULT and aborted instructions are not counted.
- Latency: data-proc 4 cycles, load 5, store 4, branch 3 (each including 1 FETCH cycle with zero wait).

Test Plan:
- Reset, then data-proc: rst=0 for 2 cycles, then op=00, set_flags=1, alu_flags=4'b0100, mem_ready=1 → state FETCH→DECODE→EXEC→WB_ALU. flags_q=0100 after EXEC, rf_we=1 in WB_ALU, retired=1.
- Branch conditions:
  - flags_q=0100 (Z): cond=11 → pc_we=1, pc_src=1, branch_taken=1.
  - flags_q=0000, cond=01 → taken.
  - flags_q=1000 (N≠V), cond=01 → not taken.
  - cond=10 → never taken.
  - retired increments in every case.
- Load with waits: op=01, is_load=1, mem_ready held 0 for 3 cycles in MEM_RD → mem_req=1 for 4 cycles, then WB_MEM with rf_we=1, wb_src=1. Total 8 cycles.
- Store: op=01, is_load=0 → mem_we=1 and addr_src=1 in MEM_WR; retire on the ready cycle; next state FETCH.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 forever in FETCH → FAULT after 4 wait cycles. fault=1, mem_req=0 thereafter, retired unchanged. Variant: mem_ready=1 on cycle 4 → normal DECODE.
- Halt and reset mid-op:
  - op=11 → halted=1 permanently, no enables.
  - rst=0 during MEM_RD → next cycle state FETCH, flags_q=0, retired=0. mem_req=0 while rst=0.
